// File: rtl/lu_coeff_loader.sv
// Operand stage for the 3x3 LU solver: collects nine coefficients and three
// right-hand-side words from the front panel, holds them on a packed bus and
// runs the solver en/done handshake with a pivot pre-check and a watchdog.
module lu_coeff_loader #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load,
    input  logic                 start,
    input  logic                 ack,
    input  logic                 clr,
    input  logic                 solver_done,
    input  logic                 solver_err,
    output logic [12*WIDTH-1:0]  coef,
    output logic                 en,
    output logic [3:0]           idx,
    output logic                 full,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 err_pivot,
    output logic                 err_timeout,
    output logic                 err_solver
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StLoad, StFull, StRun, StHold, StErr} state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] coef_q [12];
    logic             coef_we;
    logic             load_q, start_q, ack_q;
    logic [WdW-1:0]   wd_q, wd_d;
    logic             err_pivot_q, err_pivot_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_solver_q, err_solver_d;
    // settle_q marks the first FULL cycle after HOLD; a start edge seen there
    // is parked in pend_q so en stays low for at least two cycles.
    logic             settle_q, settle_d;
    logic             pend_q, pend_d;

    logic load_edge, start_edge, ack_edge;

    assign load_edge  = load & ~load_q;
    assign start_edge = start & ~start_q;
    assign ack_edge   = ack & ~ack_q;

    // Button edge detectors: one register stage per level input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            load_q  <= load;
            start_q <= start;
            ack_q   <= ack;
        end
    end

    // Control state, entry index, watchdog and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StLoad;
            idx_q         <= 4'd0;
            wd_q          <= '0;
            err_pivot_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_solver_q  <= 1'b0;
            settle_q      <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wd_q          <= wd_d;
            err_pivot_q   <= err_pivot_d;
            err_timeout_q <= err_timeout_d;
            err_solver_q  <= err_solver_d;
            settle_q      <= settle_d;
            pend_q        <= pend_d;
        end
    end

    // Coefficient storage; written only from LOAD, one slot per load edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 12; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 12; k++) begin
                if (coef_we && (idx_q == 4'(k))) begin
                    coef_q[k] <= data_in;
                end
            end
        end
    end

    // Next-state logic; clr overrides every other event.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wd_d          = wd_q;
        err_pivot_d   = err_pivot_q;
        err_timeout_d = err_timeout_q;
        err_solver_d  = err_solver_q;
        settle_d      = 1'b0;
        pend_d        = 1'b0;
        coef_we       = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (load_edge) begin
                    coef_we = 1'b1;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd11) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (settle_q) begin
                    pend_d = start_edge;
                end else if (start_edge || pend_q) begin
                    if (coef_q[0] == '0) begin
                        state_d     = StErr;
                        err_pivot_d = 1'b1;
                    end else begin
                        state_d       = StRun;
                        wd_d          = '0;
                        err_pivot_d   = 1'b0;
                        err_timeout_d = 1'b0;
                        err_solver_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (solver_err) begin
                    err_solver_d = 1'b1;
                end
                if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
                // done takes priority over a same-cycle watchdog expiry
                if (solver_done) begin
                    state_d = StHold;
                end else if (wd_q == WdLast) begin
                    state_d       = StErr;
                    err_timeout_d = 1'b1;
                end
            end
            StHold: begin
                if (ack_edge) begin
                    state_d  = StFull;
                    settle_d = 1'b1;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        if (clr) begin
            state_d       = StLoad;
            idx_d         = 4'd0;
            err_pivot_d   = 1'b0;
            err_timeout_d = 1'b0;
            err_solver_d  = 1'b0;
            settle_d      = 1'b0;
            pend_d        = 1'b0;
            coef_we       = 1'b0;
        end
    end

    // Output decode, all taken directly from registered state.
    always_comb begin
        coef = '0;
        for (int k = 0; k < 12; k++) begin
            coef[WIDTH*k +: WIDTH] = coef_q[k];
        end
        en           = (state_q == StRun) || (state_q == StHold);
        busy         = (state_q == StRun);
        result_valid = (state_q == StHold);
        idx          = idx_q;
        full         = (idx_q == 4'd12);
        err_pivot    = err_pivot_q;
        err_timeout  = err_timeout_q;
        err_solver   = err_solver_q;
    end

endmodule
